// File: rtl/rot_seq_ctrl.sv
// Command-driven controller for a WIDTH-bit rotating register: load a pattern, rotate it N steps, pulse done.
// Optional abort support is enabled by defining ROT_SEQ_ABORT_EN.
module rot_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNTW  = 4
) (
    input  logic             c,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [CNTW-1:0]  steps,
    input  logic             dir,
`ifdef ROT_SEQ_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic [CNTW-1:0]  rem,
    output logic [1:0]       dbg_state
);

    // Handshake: start is sampled only while busy=0; a command is accepted at that edge,
    // busy then stays high until the edge leaving DONE, and done pulses for exactly that last cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    logic   dir_q;

    always_ff @(posedge c) begin
        if (rst) begin
            state <= IDLE;
            q     <= '0;
            rem   <= '0;
            dir_q <= 1'b0;
`ifdef ROT_SEQ_ABORT_EN
            aborted <= 1'b0;
`endif
        end else begin
`ifdef ROT_SEQ_ABORT_EN
            aborted <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        q     <= din;
                        rem   <= steps;
                        dir_q <= dir;
                        state <= (steps != '0) ? ROT : DONE;
                    end
                end
                ROT: begin
`ifdef ROT_SEQ_ABORT_EN
                    if (abort) begin
                        // q keeps its partially rotated value
                        rem     <= '0;
                        aborted <= 1'b1;
                        state   <= IDLE;
                    end else
`endif
                    begin
                        if (dir_q)
                            q <= {q[0], q[WIDTH-1:1]};
                        else
                            q <= {q[WIDTH-2:0], q[WIDTH-1]};
                        rem <= rem - CNTW'(1);
                        if (rem == CNTW'(1))
                            state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded straight from the state register
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_rot_seq_ctrl.sv
// Directed bench for rot_seq_ctrl: command table plus hand-written corner sequences.
// Exercises the abort path when ROT_SEQ_ABORT_EN is defined.
module tb_rot_seq_ctrl;

  localparam int WIDTH = 4;
  localparam int CNTW  = 4;

  logic             c;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] din;
  logic [CNTW-1:0]  steps;
  logic             dir;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic [CNTW-1:0]  rem;
  logic [1:0]       dbg_state;
`ifdef ROT_SEQ_ABORT_EN
  logic             abort;
  logic             aborted;
`endif

  rot_seq_ctrl #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .c         (c),
    .rst       (rst),
    .start     (start),
    .din       (din),
    .steps     (steps),
    .dir       (dir),
`ifdef ROT_SEQ_ABORT_EN
    .abort     (abort),
    .aborted   (aborted),
`endif
    .q         (q),
    .busy      (busy),
    .done      (done),
    .rem       (rem),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial c = 1'b0;
  always #5 c = ~c;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  typedef struct {
    logic [WIDTH-1:0] din;
    logic [CNTW-1:0]  steps;
    logic             dir;
    logic [WIDTH-1:0] exp_q;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  // drive a command so that it is accepted at the next edge (E0); returns just after E0
  task automatic issue(input logic [WIDTH-1:0] d, input logic [CNTW-1:0] s, input logic r);
    start = 1'b1;
    din   = d;
    steps = s;
    dir   = r;
    tick();
    start = 1'b0;
  endtask

  // wait (bounded) until done is seen; n = edges after E0
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int done_cnt;

    vecs[0] = '{4'b0011, 4'd1,  1'b0, 4'b0110};
    vecs[1] = '{4'b0011, 4'd4,  1'b0, 4'b0011};
    vecs[2] = '{4'b0011, 4'd1,  1'b1, 4'b1001};
    vecs[3] = '{4'b1010, 4'd0,  1'b0, 4'b1010};
    vecs[4] = '{4'b0001, 4'd2,  1'b0, 4'b0100};
    vecs[5] = '{4'b0001, 4'd3,  1'b1, 4'b0010};
    vecs[6] = '{4'b1000, 4'd1,  1'b0, 4'b0001};
    vecs[7] = '{4'b0110, 4'd15, 1'b0, 4'b0011};
    vecs[8] = '{4'b1101, 4'd5,  1'b1, 4'b1110};
    vecs[9] = '{4'b0101, 4'd2,  1'b1, 4'b0101};

    rst   = 1'b1;
    start = 1'b0;
    din   = '0;
    steps = '0;
    dir   = 1'b0;
`ifdef ROT_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    tick();
    chk("reset_q", 32'(q), 32'h0);
    chk("reset_rem", 32'(rem), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_state", 32'(dbg_state), 32'h0);
`ifdef ROT_SEQ_ABORT_EN
    chk("reset_aborted", 32'(aborted), 32'h0);
`endif
    rst = 1'b0;
    tick();

    // table of commands
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].din, vecs[i].steps, vecs[i].dir);
      chk($sformatf("v%0d_busy_e0", i), 32'(busy), 32'h1);
      wait_done(n);
      chk($sformatf("v%0d_latency", i), 32'(n), 32'(vecs[i].steps));
      chk($sformatf("v%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
      chk($sformatf("v%0d_rem", i), 32'(rem), 32'h0);
      tick();
      chk($sformatf("v%0d_done_clr", i), 32'(done), 32'h0);
      chk($sformatf("v%0d_busy_clr", i), 32'(busy), 32'h0);
      chk($sformatf("v%0d_q_hold", i), 32'(q), 32'(vecs[i].exp_q));
    end

    // step-by-step walk through a 4-step left rotation
    exp_q = '{4'b0011, 4'b0110, 4'b1100, 4'b1001, 4'b0011};
    issue(4'b0011, 4'd4, 1'b0);
    for (int k = 0; k < 5; k++) begin
      logic [WIDTH-1:0] e;
      e = exp_q.pop_front();
      chk($sformatf("walk_q%0d", k), 32'(q), 32'(e));
      chk($sformatf("walk_rem%0d", k), 32'(rem), 32'(4 - k));
      chk($sformatf("walk_done%0d", k), 32'(done), (k == 4) ? 32'h1 : 32'h0);
      if (k < 4) tick();
    end
    tick();

    // inputs changing mid-run have no effect (dir latched)
    issue(4'b0011, 4'd3, 1'b1);
    dir   = 1'b0;
    din   = 4'b1111;
    steps = 4'd9;
    tick();
    dir = 1'b1;
    tick();
    dir = 1'b0;
    wait_done(n);
    chk("toggle_latency", 32'(n), 32'd1);
    chk("toggle_q", 32'(q), 32'b0110);
    tick();

    // steps=0, plus a start pulsed during DONE must be ignored
    issue(4'b1010, 4'd0, 1'b0);
    chk("zero_q", 32'(q), 32'b1010);
    chk("zero_done", 32'(done), 32'h1);
    start = 1'b1;
    din   = 4'b0000;
    steps = 4'd2;
    tick();
    start = 1'b0;
    chk("zero_busy_clr", 32'(busy), 32'h0);
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (done || busy) done_cnt++;
      tick();
    end
    chk("ignored_start_activity", 32'(done_cnt), 32'h0);
    chk("ignored_start_q", 32'(q), 32'b1010);

    // reset mid-rotation
    issue(4'b0001, 4'd5, 1'b0);
    tick();
    tick();
    chk("pre_rst_rem", 32'(rem), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_q", 32'(q), 32'h0);
    chk("midrst_rem", 32'(rem), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) done_cnt++;
      tick();
    end
    chk("midrst_no_done", 32'(done_cnt), 32'h0);
    issue(4'b0001, 4'd2, 1'b0);
    wait_done(n);
    chk("post_rst_latency", 32'(n), 32'd2);
    chk("post_rst_q", 32'(q), 32'b0100);
    tick();

`ifdef ROT_SEQ_ABORT_EN
    // abort after the first rotation
    issue(4'b0001, 4'd3, 1'b0);
    tick();
    chk("abort_pre_q", 32'(q), 32'b0010);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_q", 32'(q), 32'b0010);
    chk("abort_pulse", 32'(aborted), 32'h1);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_rem", 32'(rem), 32'h0);
    done_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done || aborted) done_cnt++;
    end
    chk("abort_after_quiet", 32'(done_cnt), 32'h0);
    chk("abort_q_hold", 32'(q), 32'b0010);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
